// File: rtl/out_fifo_sync_if.sv
// Fabric/PHY handshake bundle for the output FIFO: byte-wide write side,
// nibble-wide read side, plus the status flags.
interface out_fifo_sync_if #(
    parameter int LANES = 10
);
    logic                 i_wr_en;
    logic [LANES*8-1:0]   i_d;
    logic                 i_rd_en;
    logic [LANES*4-1:0]   o_q;
    logic                 o_empty;
    logic                 o_full;
    logic                 o_almost_empty;
    logic                 o_almost_full;
    logic                 o_err;

    modport master (
        output i_wr_en, i_d, i_rd_en,
        input  o_q, o_empty, o_full, o_almost_empty, o_almost_full, o_err
    );

    modport slave (
        input  i_wr_en, i_d, i_rd_en,
        output o_q, o_empty, o_full, o_almost_empty, o_almost_full, o_err
    );
endinterface

// File: rtl/out_fifo_sync.sv
// PHY output FIFO: bytes per lane in, nibbles per lane out (low nibble first).
// Define OUT_FIFO_ERR_CHECK_EN to build the sticky overflow/underflow flag o_err.
module out_fifo_sync #(
    parameter int LANES              = 10,
    parameter int DEPTH              = 8,
    parameter int ARRAY_MODE_8X4     = 1,
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    out_fifo_sync_if.slave fifo
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = LANES * 8;
    localparam int QW = LANES * 4;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("out_fifo_sync: DEPTH must be a power of two and at least 4");
    end
    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > 2) begin : g_bad_ae
        $error("out_fifo_sync: ALMOST_EMPTY_VALUE must be 1..2");
    end
    if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > 2) begin : g_bad_af
        $error("out_fifo_sync: ALMOST_FULL_VALUE must be 1..2");
    end

    typedef enum logic {PH_LO, PH_HI} ph_t;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    ph_t           ph;
    ph_t           ph_nxt;
    logic [QW-1:0] q_r;
    logic [DW-1:0] rd_entry;
    logic [QW-1:0] rd_nib;
    logic          wr_ok;
    logic          rd_ok;
    logic          pop;
    logic          empty;
    logic          full;

    // Flags decode the registered count only; pointers never decide full/empty.
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    assign fifo.o_empty        = empty;
    assign fifo.o_full         = full;
    assign fifo.o_almost_empty = (cnt <= CW'(ALMOST_EMPTY_VALUE));
    assign fifo.o_almost_full  = (cnt >= CW'(DEPTH - ALMOST_FULL_VALUE));
    assign fifo.o_q            = q_r;

    assign wr_ok = fifo.i_wr_en & ~full;
    assign rd_ok = fifo.i_rd_en & ~empty;

    // Nibble phase: in 8x4 mode the first read of an entry only advances the phase.
    always_comb begin
        ph_nxt = ph;
        pop    = 1'b0;
        if (rd_ok) begin
            if (ARRAY_MODE_8X4 != 0 && ph == PH_LO) begin
                ph_nxt = PH_HI;
            end else begin
                ph_nxt = PH_LO;
                pop    = 1'b1;
            end
        end
    end

    always_comb begin
        rd_entry = mem[rp];
        rd_nib   = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_nib[4*k +: 4] = (ph == PH_HI) ? rd_entry[8*k+4 +: 4] : rd_entry[8*k +: 4];
        end
    end

    // Storage is deliberately left out of reset; only pointers and count matter.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wp] <= fifo.i_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ph  <= PH_LO;
            q_r <= '0;
        end else begin
            ph <= ph_nxt;
            if (wr_ok) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (rd_ok) begin
                q_r <= rd_nib;
            end
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef OUT_FIFO_ERR_CHECK_EN
    logic err_r;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            err_r <= 1'b0;
        end else if ((fifo.i_wr_en & full) | (fifo.i_rd_en & empty)) begin
            err_r <= 1'b1;
        end
    end

    assign fifo.o_err = err_r;
`else
    assign fifo.o_err = 1'b0;
`endif

endmodule
